// File: rtl/apb_sync_decoupler_pkg.sv
// Shared types and helpers for the single-clock APB decoupler.
package apb_sync_decoupler_pkg;

   typedef enum logic {
      UP_IDLE,
      UP_WAIT_RESP
   } up_state_e;

   typedef enum logic [1:0] {
      DN_IDLE,
      DN_SETUP,
      DN_ACCESS
   } dn_state_e;

   // One strobe bit per started byte, so odd data widths still get a strobe for the top bits.
   function automatic int strb_width(input int data_width);
      return (data_width + 7) / 8;
   endfunction

endpackage

// File: rtl/apb_sync_decoupler_fifo.sv
// Generic synchronous FIFO, DEPTH = 2**LOG_DEPTH, show-ahead read port.
module sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int LOG_DEPTH = 1
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 2 ** LOG_DEPTH;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [LOG_DEPTH:0] wr_ptr;
   logic [LOG_DEPTH:0] rd_ptr;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                  (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
   assign rdata = mem[rd_ptr[LOG_DEPTH-1:0]];

   // Pointer update; pushes while full and pops while empty are ignored.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + (LOG_DEPTH+1)'(1);
         if (pop  && !empty) rd_ptr <= rd_ptr + (LOG_DEPTH+1)'(1);
      end
   end

   // Storage needs no reset: the empty flag guards every read.
   always_ff @(posedge clk_sys) begin
      if (push && !full) mem[wr_ptr[LOG_DEPTH-1:0]] <= wdata;
   end

endmodule

// File: rtl/apb_sync_decoupler.sv
// APB timing/protocol cut: upstream transfers are queued and replayed downstream
// as full setup/access transfers; responses return through a second FIFO.
//
// state        | meaning
// UP_IDLE      | waiting for upstream psel; request is queued on that edge
// UP_WAIT_RESP | request queued; pready raised once a response is available
// DN_IDLE      | waiting for a queued request
// DN_SETUP     | downstream setup phase (psel=1, penable=0)
// DN_ACCESS    | downstream access phase, held until dst_pready_i
module apb_sync_decoupler
   import apb_sync_decoupler_pkg::*;
#(
   parameter  int APB_ADDR_WIDTH = 32,
   parameter  int APB_DATA_WIDTH = 32,
   parameter  int LOG_DEPTH      = 1,
   localparam int APB_STRB_WIDTH = strb_width(APB_DATA_WIDTH)
) (
   input  logic                      pclk_i,
   input  logic                      preset_ni,
   input  logic [APB_ADDR_WIDTH-1:0] src_paddr_i,
   input  logic [2:0]                src_pprot_i,
   input  logic                      src_psel_i,
   input  logic                      src_penable_i,
   input  logic                      src_pwrite_i,
   input  logic [APB_DATA_WIDTH-1:0] src_pwdata_i,
   input  logic [APB_STRB_WIDTH-1:0] src_pstrb_i,
   output logic                      src_pready_o,
   output logic [APB_DATA_WIDTH-1:0] src_prdata_o,
   output logic                      src_pslverr_o,
   output logic [APB_ADDR_WIDTH-1:0] dst_paddr_o,
   output logic [2:0]                dst_pprot_o,
   output logic                      dst_psel_o,
   output logic                      dst_penable_o,
   output logic                      dst_pwrite_o,
   output logic [APB_DATA_WIDTH-1:0] dst_pwdata_o,
   output logic [APB_STRB_WIDTH-1:0] dst_pstrb_o,
   input  logic                      dst_pready_i,
   input  logic [APB_DATA_WIDTH-1:0] dst_prdata_i,
   input  logic                      dst_pslverr_i
);

   // Widths depend on module parameters, so the transfer records are declared here.
   typedef struct packed {
      logic [APB_ADDR_WIDTH-1:0] addr;
      logic [2:0]                prot;
      logic                      write;
      logic [APB_DATA_WIDTH-1:0] wdata;
      logic [APB_STRB_WIDTH-1:0] strb;
   } req_t;

   typedef struct packed {
      logic [APB_DATA_WIDTH-1:0] rdata;
      logic                      slverr;
   } resp_t;

   up_state_e up_state_q, up_state_d;
   dn_state_e dn_state_q, dn_state_d;

   req_t  req_in, req_head, req_q;
   resp_t resp_in, resp_head;
   logic  req_push, req_pop, req_full, req_empty;
   logic  resp_push, resp_pop, resp_full, resp_empty;

   // penable is implied by the upstream FSM: only the setup edge in UP_IDLE pushes.
   logic unused_penable;
   assign unused_penable = src_penable_i;

   assign req_in  = {src_paddr_i, src_pprot_i, src_pwrite_i, src_pwdata_i, src_pstrb_i};
   assign resp_in = {dst_prdata_i, dst_pslverr_i};

   sync_fifo #(.WIDTH($bits(req_t)), .LOG_DEPTH(LOG_DEPTH)) u_req_fifo (
      .clk_sys (pclk_i),
      .rst_b   (preset_ni),
      .push    (req_push),
      .wdata   (req_in),
      .pop     (req_pop),
      .rdata   (req_head),
      .full    (req_full),
      .empty   (req_empty)
   );

   sync_fifo #(.WIDTH($bits(resp_t)), .LOG_DEPTH(LOG_DEPTH)) u_resp_fifo (
      .clk_sys (pclk_i),
      .rst_b   (preset_ni),
      .push    (resp_push),
      .wdata   (resp_in),
      .pop     (resp_pop),
      .rdata   (resp_head),
      .full    (resp_full),
      .empty   (resp_empty)
   );

   // State registers for both sides.
   always_ff @(posedge pclk_i or negedge preset_ni) begin
      if (!preset_ni) begin
         up_state_q <= UP_IDLE;
         dn_state_q <= DN_IDLE;
      end else begin
         up_state_q <= up_state_d;
         dn_state_q <= dn_state_d;
      end
   end

   // Upstream side: queue the request, then complete it from the response FIFO head.
   always_comb begin
      up_state_d    = up_state_q;
      req_push      = 1'b0;
      resp_pop      = 1'b0;
      src_pready_o  = 1'b0;
      src_prdata_o  = '0;
      src_pslverr_o = 1'b0;
      case (up_state_q)
         UP_IDLE: begin
            if (src_psel_i && !req_full) begin
               req_push   = 1'b1;
               up_state_d = UP_WAIT_RESP;
            end
         end
         UP_WAIT_RESP: begin
            if (!resp_empty) begin
               src_pready_o  = 1'b1;
               src_prdata_o  = resp_head.rdata;
               src_pslverr_o = resp_head.slverr;
               resp_pop      = 1'b1;
               up_state_d    = UP_IDLE;
            end
         end
         default: up_state_d = UP_IDLE;
      endcase
   end

   // Downstream side: replay each queued request as setup then access.
   always_comb begin
      dn_state_d    = dn_state_q;
      req_pop       = 1'b0;
      resp_push     = 1'b0;
      dst_psel_o    = 1'b0;
      dst_penable_o = 1'b0;
      case (dn_state_q)
         DN_IDLE: begin
            if (!req_empty) begin
               req_pop    = 1'b1;
               dn_state_d = DN_SETUP;
            end
         end
         DN_SETUP: begin
            dst_psel_o = 1'b1;
            dn_state_d = DN_ACCESS;
         end
         DN_ACCESS: begin
            dst_psel_o    = 1'b1;
            dst_penable_o = 1'b1;
            if (dst_pready_i) begin
               resp_push  = 1'b1;
               dn_state_d = DN_IDLE;
            end
         end
         default: dn_state_d = DN_IDLE;
      endcase
   end

   // Request fields are held here so they stay stable through setup and access.
   always_ff @(posedge pclk_i or negedge preset_ni) begin
      if (!preset_ni) req_q <= '0;
      else if (req_pop) req_q <= req_head;
   end

   assign dst_paddr_o  = req_q.addr;
   assign dst_pprot_o  = req_q.prot;
   assign dst_pwrite_o = req_q.write;
   assign dst_pwdata_o = req_q.wdata;
   assign dst_pstrb_o  = req_q.strb;

   // Only one transfer is ever outstanding, so the response FIFO cannot overflow.
   assert property (@(posedge pclk_i) disable iff (!preset_ni) !(resp_push && resp_full))
      else $error("response FIFO overflow");

endmodule

// File: tb/tb_apb_sync_decoupler.sv
module tb_apb_sync_decoupler;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int WDW = 27;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [AW-1:0] src_paddr;  logic [2:0] src_pprot;
   logic src_psel, src_penable, src_pwrite;
   logic [DW-1:0] src_pwdata; logic [SW-1:0] src_pstrb;
   logic src_pready; logic [DW-1:0] src_prdata; logic src_pslverr;
   logic [AW-1:0] dst_paddr;  logic [2:0] dst_pprot;
   logic dst_psel, dst_penable, dst_pwrite;
   logic [DW-1:0] dst_pwdata; logic [SW-1:0] dst_pstrb;
   logic dst_pready; logic [DW-1:0] dst_prdata; logic dst_pslverr;

   apb_sync_decoupler u_dut (
      .pclk_i(clk), .preset_ni(rst_n),
      .src_paddr_i(src_paddr), .src_pprot_i(src_pprot), .src_psel_i(src_psel),
      .src_penable_i(src_penable), .src_pwrite_i(src_pwrite), .src_pwdata_i(src_pwdata),
      .src_pstrb_i(src_pstrb), .src_pready_o(src_pready), .src_prdata_o(src_prdata),
      .src_pslverr_o(src_pslverr),
      .dst_paddr_o(dst_paddr), .dst_pprot_o(dst_pprot), .dst_psel_o(dst_psel),
      .dst_penable_o(dst_penable), .dst_pwrite_o(dst_pwrite), .dst_pwdata_o(dst_pwdata),
      .dst_pstrb_o(dst_pstrb), .dst_pready_i(dst_pready), .dst_prdata_i(dst_prdata),
      .dst_pslverr_i(dst_pslverr)
   );

   // 27-bit data instance, hand driven
   logic [AW-1:0] w_src_paddr = '0; logic [2:0] w_src_pprot = '0;
   logic w_src_psel = 0, w_src_penable = 0, w_src_pwrite = 0;
   logic [WDW-1:0] w_src_pwdata = '0; logic [3:0] w_src_pstrb = '0;
   logic w_src_pready; logic [WDW-1:0] w_src_prdata; logic w_src_pslverr;
   logic [AW-1:0] w_dst_paddr; logic [2:0] w_dst_pprot;
   logic w_dst_psel, w_dst_penable, w_dst_pwrite;
   logic [WDW-1:0] w_dst_pwdata; logic [3:0] w_dst_pstrb;
   logic w_dst_pready = 1'b1; logic [WDW-1:0] w_dst_prdata = 27'h555_5555; logic w_dst_pslverr = 1'b0;

   apb_sync_decoupler #(.APB_DATA_WIDTH(WDW)) u_dut27 (
      .pclk_i(clk), .preset_ni(rst_n),
      .src_paddr_i(w_src_paddr), .src_pprot_i(w_src_pprot), .src_psel_i(w_src_psel),
      .src_penable_i(w_src_penable), .src_pwrite_i(w_src_pwrite), .src_pwdata_i(w_src_pwdata),
      .src_pstrb_i(w_src_pstrb), .src_pready_o(w_src_pready), .src_prdata_o(w_src_prdata),
      .src_pslverr_o(w_src_pslverr),
      .dst_paddr_o(w_dst_paddr), .dst_pprot_o(w_dst_pprot), .dst_psel_o(w_dst_psel),
      .dst_penable_o(w_dst_penable), .dst_pwrite_o(w_dst_pwrite), .dst_pwdata_o(w_dst_pwdata),
      .dst_pstrb_o(w_dst_pstrb), .dst_pready_i(w_dst_pready), .dst_prdata_i(w_dst_prdata),
      .dst_pslverr_i(w_dst_pslverr)
   );

   typedef struct packed {
      logic [AW-1:0] addr; logic [2:0] prot; logic write; logic [DW-1:0] wdata; logic [SW-1:0] strb;
   } req_s;
   typedef struct packed { logic [DW-1:0] rdata; logic slverr; } rsp_s;
   typedef struct { int unsigned waits; logic [DW-1:0] rdata; logic slverr; } plan_s;
   typedef struct {
      req_s r; int unsigned gap; int unsigned waits; logic [DW-1:0] rdata; logic slverr; int exp_lat;
   } vec_s;

   req_s  exp_req_q[$];
   rsp_s  exp_rsp_q[$];
   plan_s plan_q[$];

   int n_checks = 0;
   int n_pass = 0;
   bit aborted = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // Downstream completer: checks each replayed request, answers after planned or random waits.
   initial begin
      int unsigned cnt;
      logic active, stable_ok;
      req_s seen;
      plan_s p;
      dst_pready = 0; dst_prdata = '0; dst_pslverr = 0;
      active = 0; stable_ok = 1; cnt = 0; seen = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            active = 0; dst_pready = 0;
         end else if (dst_psel && !dst_penable) begin
            seen = {dst_paddr, dst_pprot, dst_pwrite, dst_pwdata, dst_pstrb};
            if (exp_req_q.size() == 0) chk("dst_spurious_req", 128'(seen), 128'(0));
            else chk("dst_req", 128'(seen), 128'(exp_req_q.pop_front()));
            if (plan_q.size() != 0) p = plan_q.pop_front();
            else p = '{$urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1))};
            cnt = p.waits; dst_prdata = p.rdata; dst_pslverr = p.slverr; dst_pready = 0;
            exp_rsp_q.push_back({p.rdata, p.slverr});
            active = 1; stable_ok = 1;
         end else if (dst_psel && dst_penable && active) begin
            if ({dst_paddr, dst_pprot, dst_pwrite, dst_pwdata, dst_pstrb} !== seen) stable_ok = 0;
            dst_pready = (cnt == 0);
            if (cnt > 0) cnt--;
            if (dst_pready) chk("dst_fields_stable", 128'(stable_ok), 128'(1));
         end else begin
            dst_pready = 0;
            if (!dst_psel) active = 0;
         end
      end
   end

   // One upstream transfer; entered and left at #1 after a clock edge.
   task automatic xfer(input req_s r, output rsp_s got, output int lat);
      bit leak;
      leak = 0; lat = -1; got = '0;
      src_paddr = r.addr; src_pprot = r.prot; src_pwrite = r.write;
      src_pwdata = r.wdata; src_pstrb = r.strb; src_psel = 1; src_penable = 0;
      exp_req_q.push_back(r);
      @(posedge clk); #1;
      src_penable = 1;
      for (int n = 0; n < 100; n++) begin
         if (src_pready) begin
            lat = n; got = {src_prdata, src_pslverr};
            break;
         end
         if (src_prdata !== '0 || src_pslverr !== 1'b0) leak = 1;
         @(posedge clk); #1;
      end
      if (lat < 0) begin
         chk("src_timeout", 128'(0), 128'(1));
         aborted = 1;
      end else begin
         @(posedge clk); #1;
         chk("src_pready_single", 128'(src_pready), 128'(0));
         if (exp_rsp_q.size() == 0) chk("src_spurious_rsp", 128'(got), 128'(0));
         else chk("src_rsp", 128'(got), 128'(exp_rsp_q.pop_front()));
      end
      chk("src_idle_zero", 128'(leak), 128'(0));
      src_psel = 0; src_penable = 0;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, actual running required done");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_s vecs[6];
      rsp_s got;
      int lat;
      req_s r;

      vecs[0] = '{'{32'h0000_0010, 3'd0, 1'b1, 32'h0123_4567, 4'hF}, 2, 0, 32'hDEAD_0001, 1'b0, 3};
      vecs[1] = '{'{32'h0000_0004, 3'd2, 1'b0, 32'h0, 4'h0}, 3, 4, 32'h05A5_A5A5, 1'b1, 7};
      vecs[2] = '{'{32'h0000_0000, 3'd0, 1'b0, 32'h0, 4'h0}, 3, 0, 32'h1111_0000, 1'b0, 3};
      vecs[3] = '{'{32'h0000_0004, 3'd0, 1'b0, 32'h0, 4'h0}, 0, 1, 32'h2222_0004, 1'b0, 4};
      vecs[4] = '{'{32'h0000_0008, 3'd0, 1'b0, 32'h0, 4'h0}, 0, 2, 32'h3333_0008, 1'b1, 5};
      vecs[5] = '{'{32'hFFFF_FFFC, 3'd7, 1'b1, 32'hFFFF_FFFF, 4'h5}, 0, 3, 32'h0BAD_F00D, 1'b1, 6};

      rst_n = 0;
      src_paddr = '0; src_pprot = '0; src_psel = 0; src_penable = 0;
      src_pwrite = 0; src_pwdata = '0; src_pstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dst_ctrl", 128'({dst_psel, dst_penable, dst_pwrite}), 128'(0));
      chk("rst_dst_fields", 128'({dst_paddr, dst_pprot, dst_pwdata, dst_pstrb}), 128'(0));
      chk("rst_src_outs", 128'({src_pready, src_prdata, src_pslverr}), 128'(0));
      rst_n = 1;
      @(posedge clk); #1;

      // 27-bit data path
      begin
         int wl;
         wl = -1;
         w_src_paddr = 32'h40; w_src_pwrite = 1; w_src_pwdata = 27'h7FF_FFFF; w_src_pstrb = 4'hF;
         w_src_psel = 1; w_src_penable = 0;
         @(posedge clk); #1;
         w_src_penable = 1;
         for (int n = 0; n < 20; n++) begin
            if (w_dst_psel && !w_dst_penable)
               chk("w27_pwdata", 128'({w_dst_pwdata, w_dst_pstrb}), 128'({27'h7FF_FFFF, 4'hF}));
            if (w_src_pready) begin
               wl = n;
               chk("w27_prdata", 128'({w_src_prdata, w_src_pslverr}), 128'({27'h555_5555, 1'b0}));
               break;
            end
            @(posedge clk); #1;
         end
         chk("w27_latency", 128'(wl), 128'(3));
         @(posedge clk); #1;
         w_src_psel = 0; w_src_penable = 0;
      end

      // Directed vectors, including back-to-back reads
      for (int i = 0; i < 6 && !aborted; i++) begin
         repeat (vecs[i].gap) begin @(posedge clk); #1; end
         plan_q.push_back('{vecs[i].waits, vecs[i].rdata, vecs[i].slverr});
         xfer(vecs[i].r, got, lat);
         chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_resp", i), 128'(got), 128'({vecs[i].rdata, vecs[i].slverr}));
      end

      // Random traffic
      for (int i = 0; i < 1000 && !aborted; i++) begin
         repeat ($urandom_range(0, 10)) begin @(posedge clk); #1; end
         r = {32'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              32'($urandom), 4'($urandom_range(0, 15))};
         xfer(r, got, lat);
      end

      // Reset while the downstream access is stalled
      if (!aborted) begin
         bit hit;
         hit = 0;
         @(posedge clk); #1;
         plan_q.push_back('{5, 32'hCAFE_CAFE, 1'b0});
         r = {32'h0000_0020, 3'd1, 1'b1, 32'hA5A5_0000, 4'hF};
         src_paddr = r.addr; src_pprot = r.prot; src_pwrite = r.write;
         src_pwdata = r.wdata; src_pstrb = r.strb; src_psel = 1; src_penable = 0;
         exp_req_q.push_back(r);
         @(posedge clk); #1;
         src_penable = 1;
         for (int n = 0; n < 20; n++) begin
            if (dst_penable) begin hit = 1; break; end
            @(posedge clk); #1;
         end
         chk("rst_reached_access", 128'(hit), 128'(1));
         #2 rst_n = 0;
         #1;
         chk("rst_async_dst", 128'({dst_psel, dst_penable, dst_pwrite, dst_paddr, dst_pprot, dst_pwdata, dst_pstrb}), 128'(0));
         chk("rst_async_src", 128'({src_pready, src_prdata, src_pslverr}), 128'(0));
         src_psel = 0; src_penable = 0;
         exp_req_q.delete(); exp_rsp_q.delete(); plan_q.delete();
         repeat (2) @(posedge clk);
         #1 rst_n = 1;
         @(posedge clk); #1;
         plan_q.push_back('{0, 32'h7777_1234, 1'b1});
         xfer({32'h0000_0030, 3'd0, 1'b0, 32'h0, 4'h0}, got, lat);
         chk("post_rst_latency", 128'(lat), 128'(3));
         chk("post_rst_resp", 128'(got), 128'({32'h7777_1234, 1'b1}));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("req_queue_drained", 128'(exp_req_q.size()), 128'(0));
      chk("rsp_queue_drained", 128'(exp_rsp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
